// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: two valid/ready request ports and
// one backpressured, ID-tagged response channel.
interface shift_arbiter_if #(
   parameter int W = 32
);
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req_data0;
   logic [W-1:0] req_data1;
   logic [1:0]   req_rl;
   logic [1:0]   req_arith;
   logic [4:0]   req_amt0;
   logic [4:0]   req_amt1;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_id;

   modport master (
      output req_valid, req_data0, req_data1, req_rl, req_arith, req_amt0, req_amt1,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req_valid, req_data0, req_data1, req_rl, req_arith, req_amt0, req_amt1,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id
   );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port arbiter plus OP/RSP pipeline sharing one external barrel shifter.
// Define SHARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module shift_arbiter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   shift_arbiter_if.slave bus,
   output logic [W-1:0] sh_data_in,
   output logic         sh_rightleft,
   output logic         sh_arith,
   output logic [4:0]   sh_amount,
   input  logic [W-1:0] sh_data_out
);

   logic         op_valid;
   logic         op_id;
   logic         rsp_valid_q;
   logic         rsp_id_q;
   logic [W-1:0] rsp_data_q;
   logic         adv;
   logic         take;
   logic         accept;
   logic         sel;
   logic [1:0]   grant;
`ifdef SHARB_RR_EN
   logic         last;
`endif

   assign adv  = ~rsp_valid_q | bus.rsp_ready;
   assign take = ~op_valid | adv;

   // A lone requester is granted directly; only contention consults priority.
   always_comb begin
      grant = bus.req_valid;
      if (bus.req_valid == 2'b11) begin
`ifdef SHARB_RR_EN
         grant = last ? 2'b01 : 2'b10;
`else
         grant = 2'b01;
`endif
      end
   end

   assign bus.req_ready = (take & ~rst) ? grant : 2'b00;
   assign accept        = |bus.req_ready;
   assign sel           = bus.req_ready[1];

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_valid     <= 1'b0;
         op_id        <= 1'b0;
         sh_data_in   <= '0;
         sh_rightleft <= 1'b0;
         sh_arith     <= 1'b0;
         sh_amount    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
`ifdef SHARB_RR_EN
         last         <= 1'b1;
`endif
      end else begin
         if (take) begin
            op_valid <= accept;
            if (accept) begin
               op_id        <= sel;
               sh_data_in   <= sel ? bus.req_data1 : bus.req_data0;
               sh_rightleft <= bus.req_rl[sel];
               sh_arith     <= bus.req_arith[sel] & ~bus.req_rl[sel];
               sh_amount    <= sel ? bus.req_amt1 : bus.req_amt0;
`ifdef SHARB_RR_EN
               last         <= sel;
`endif
            end
         end
         if (adv) begin
            rsp_valid_q <= op_valid;
            rsp_id_q    <= op_id;
            rsp_data_q  <= sh_data_out;
         end
      end
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-port arbiter and two-stage pipeline wrapper that shares a single 32-bit barrel shifter between two requesters in the CORDIC processor. For example, the X and Y iteration paths both need `x >>> i` and `y >>> i`. The block accepts shift requests over valid/ready handshakes and grants one per cycle. It drives the shared shifter from a registered operand stage and returns each result, tagged with the requester ID, on a single backpressured response channel.

## Interface
- `W`, 32: data width; fixed at 32 to match the shifter.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 2: per-port request valid; bit k belongs to port k.
- `req_ready` output 2: per-port request ready. A request is accepted when `req_valid[k] & req_ready[k]`.
- `req_data0`, `req_data1` input 32: operands.
- `req_rl` input 2: per-port direction; 0 = right shift, 1 = left shift.
- `req_arith` input 2: per-port arithmetic flag; only meaningful for right shifts.
- `req_amt0`, `req_amt1` input 5: shift amounts, 0..31.
- `sh_data_in` output 32: operand to the shared shifter.
- `sh_rightleft` output 1: direction to the shared shifter.
- `sh_arith` output 1: arithmetic flag to the shared shifter.
- `sh_amount` output 5: shift amount to the shared shifter.
- `sh_data_out` input 32: combinational result from the shared shifter.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response ready from the consumer.
- `rsp_data` output 32: shifted result.
- `rsp_id` output 1: originating port.

## Operation
- Stage OP holds `op_valid`, `op_id` and the shifter controls; `sh_*` are driven directly from the OP registers. Stage RSP holds `rsp_valid`, `rsp_id` and `rsp_data`.
- `adv = ~rsp_valid | rsp_ready`: RSP can take a new entry.
- `take = ~op_valid | adv`: OP can take a new entry.
- Grant is computed combinationally from `req_valid` and the priority state.
  - `req_ready[k] = take & grant[k]`, so at most one bit is set.
  - `req_ready` never depends on `rsp_valid` except through `take`.
- On acceptance, OP loads the port's data, rl and amount, plus `op_id = k` and `op_valid = 1`.
  - `sh_arith` is loaded as `req_arith[k] & ~req_rl[k]`. Arithmetic fill is forced off for left shifts.
- When `take` is high and there is no acceptance, `op_valid` clears.
- When `adv` is high, RSP loads `rsp_data = sh_data_out`, `rsp_id = op_id` and `rsp_valid = op_valid`.
- Results for each port are returned in acceptance order. The whole pipeline holds while `rsp_valid & ~rsp_ready`.
- Amount 0: `rsp_data` equals the operand, for both directions and both arith settings.

## Timing
- Reset values:
  - `op_valid = 0`, `rsp_valid = 0`.
  - `rsp_data = 0`, `rsp_id = 0`.
  - `sh_data_in = 0`, `sh_rightleft = 0`, `sh_arith = 0`, `sh_amount = 0`.
  - Priority state: port 0 wins the first contention.
- `req_ready` is 0 during reset.
- Latency: a request accepted at edge N gives `rsp_valid = 1` after edge N+1 when `rsp_ready` is held high.
- Throughput: one request per cycle sustained.
- Backpressure:
  - With `rsp_valid = 1` and `rsp_ready = 0`: `rsp_data` and `rsp_id` stay stable. OP is held if valid, and `req_ready = 0` if OP is full.
  - If OP is empty during a stall, one further request is accepted into OP.
- Reset asserted mid-operation discards OP and RSP contents with no response. Requests presented during reset are not accepted.
- Simultaneous `rsp_ready` and a new acceptance in the same cycle: both happen, with no bubble.

## Configuration
- `SHARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last` register holds the port granted most recently. It resets to 1, so port 0 wins first.
  - `last` updates only on acceptance.
  - On contention, the port not equal to `last` is granted.
- `SHARB_RR_EN` undefined: fixed priority, port 0 always wins contention. Port 1 can starve. The `last` register is not instantiated.

## Test plan
- Reset check: after reset, all outputs hold their reset values. Then port 0 requests `0x80000000`, right, arith=1, amt=4 with `rsp_ready = 1`:
  - `rsp_data = 0xF8000000`, `rsp_id = 0`, two cycles after acceptance.
- Left-shift arith suppression: port 1 requests `0x80000001`, rl=1, arith=1, amt=1:
  - `sh_arith = 0`.
  - `rsp_data = 0x00000002`, `rsp_id = 1`.
- Contention, both ports valid continuously for 6 cycles:
  - With `SHARB_RR_EN`, `rsp_id` sequence is 0,1,0,1,0,1.
  - Without it, the sequence is 0,0,0,0,0,0 and `req_ready[1]` stays 0.
- Backpressure: hold `rsp_ready = 0` for 5 cycles with both ports valid:
  - Exactly one extra acceptance, into OP.
  - `rsp_data` is stable.
  - After `rsp_ready = 1`, no response is lost or duplicated, checked against a scoreboard.
- Amount 0 and 31, right shift of `0xFFFFFFFF`:
  - Logical: amt=0 gives `0xFFFFFFFF`, amt=31 gives `0x00000001`.
  - Arith amt=31 gives `0xFFFFFFFF`.
- Reset mid-stall: assert `rst` for one cycle while `rsp_valid = 1`:
  - Next cycle, `rsp_valid = 0` and `op_valid = 0`.
  - A subsequent request completes normally with the port 0 first-grant order.
